// File: rtl/systolic_ctrl.sv
// Sequencer for a linear systolic array: weight load, input streaming and pipeline drain,
// advancing the array once every P clocks and collecting results from the last PE.
module systolic_ctrl #(
    parameter int ELEMENT_BITS = 8,
    parameter int N_PE         = 4,
    parameter int P            = 4,
    parameter int VEC_LEN_W    = 8,
    localparam int IDX_W       = (N_PE > 1) ? $clog2(N_PE) : 1
) (
    input  logic                    sys_clk,
    input  logic                    reset,
    input  logic                    start,
    input  logic [VEC_LEN_W-1:0]    vec_len,
    output logic                    busy,
    output logic                    done,
    output logic                    w_load,
    output logic [IDX_W-1:0]        w_idx,
    input  logic                    in_valid,
    input  logic [ELEMENT_BITS-1:0] in_data,
    output logic                    in_ready,
    output logic                    pe_step,
    output logic [ELEMENT_BITS-1:0] arr_in_data,
    input  logic [ELEMENT_BITS-1:0] arr_out_data,
    output logic                    res_valid,
    output logic [ELEMENT_BITS-1:0] res_data
);

    localparam int NPE_BITS = $clog2(N_PE + 1);
    localparam int CNT_W    = ((VEC_LEN_W > NPE_BITS) ? VEC_LEN_W : NPE_BITS) + 1;
    localparam int DIV_W    = $clog2(P);

    localparam logic [DIV_W-1:0] DIV_MAX = DIV_W'(P - 1);
    localparam logic [DIV_W-1:0] DIV_ONE = DIV_W'(1);
    localparam logic [CNT_W-1:0] N_CNT   = CNT_W'(N_PE);
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    typedef enum logic [2:0] {
        IDLE,
        LOAD_W,
        STREAM,
        DRAIN,
        DONE
    } state_t;

    state_t                  state_q, state_d;
    logic [DIV_W-1:0]        div_q, div_d;
    logic [CNT_W-1:0]        cnt_q, cnt_d;
    logic [VEC_LEN_W-1:0]    len_q, len_d;
    logic [ELEMENT_BITS-1:0] arr_in_q, arr_in_d;
    logic                    res_valid_q, res_valid_d;
    logic [ELEMENT_BITS-1:0] res_data_q, res_data_d;

    logic             stepping;
    logic             at_edge;
    logic             stall;
    logic             step;
    logic [CNT_W-1:0] len_ext;

    always_ff @(posedge sys_clk) begin
        if (reset) begin
            state_q     <= IDLE;
            div_q       <= '0;
            cnt_q       <= '0;
            len_q       <= '0;
            arr_in_q    <= '0;
            res_valid_q <= 1'b0;
            res_data_q  <= '0;
        end else begin
            state_q     <= state_d;
            div_q       <= div_d;
            cnt_q       <= cnt_d;
            len_q       <= len_d;
            arr_in_q    <= arr_in_d;
            res_valid_q <= res_valid_d;
            res_data_q  <= res_data_d;
        end
    end

    // cnt_q is the weight index during LOAD_W and the result step counter k afterwards.
    always_comb begin
        state_d     = state_q;
        div_d       = div_q;
        cnt_d       = cnt_q;
        len_d       = len_q;
        arr_in_d    = arr_in_q;
        res_valid_d = 1'b0;
        res_data_d  = res_data_q;

        len_ext  = CNT_W'(len_q);
        stepping = (state_q == LOAD_W) || (state_q == STREAM) || (state_q == DRAIN);
        at_edge  = (div_q == DIV_MAX);
        stall    = (state_q == STREAM) && !in_valid;
        step     = stepping && at_edge && !stall;

        if (stepping) begin
            if (at_edge) begin
                div_d = stall ? div_q : '0;
            end else begin
                div_d = div_q + DIV_ONE;
            end
        end

        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d = LOAD_W;
                    len_d   = vec_len;
                    div_d   = '0;
                    cnt_d   = '0;
                end
            end
            LOAD_W: begin
                if (len_q == '0) begin
                    state_d = DONE;
                end else if (step) begin
                    if (cnt_q == N_CNT - CNT_ONE) begin
                        state_d = STREAM;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_q + CNT_ONE;
                    end
                end
            end
            STREAM: begin
                if (step) begin
                    arr_in_d = in_data;
                    cnt_d    = cnt_q + CNT_ONE;
                    if (cnt_q == len_ext - CNT_ONE) begin
                        state_d = DRAIN;
                    end
                end
            end
            DRAIN: begin
                if (step) begin
                    arr_in_d = '0;
                    cnt_d    = cnt_q + CNT_ONE;
                    if (cnt_q == len_ext + N_CNT - CNT_ONE) begin
                        state_d = DONE;
                    end
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        // The first N_PE steps after streaming begins only fill the pipeline.
        if (step && (state_q != LOAD_W) && (cnt_q >= N_CNT) && (cnt_q < len_ext + N_CNT)) begin
            res_valid_d = 1'b1;
            res_data_d  = arr_out_data;
        end
    end

    assign busy        = (state_q != IDLE);
    assign done        = (state_q == DONE);
    assign w_load      = (state_q == LOAD_W);
    assign w_idx       = (state_q == LOAD_W) ? cnt_q[IDX_W-1:0] : '0;
    assign in_ready    = (state_q == STREAM) && at_edge;
    assign pe_step     = step;
    assign arr_in_data = arr_in_q;
    assign res_valid   = res_valid_q;
    assign res_data    = res_data_q;

endmodule

// File: tb/tb_systolic_ctrl.sv
// Bench for systolic_ctrl: a step-count/elapsed-cycle model of a pass checked every cycle,
// plus literal event timings for the directed scenarios.
module tb_systolic_ctrl;

    localparam int EB  = 8;
    localparam int NP  = 4;
    localparam int PP  = 4;
    localparam int VLW = 8;

    logic          sys_clk = 1'b0;
    logic          reset = 1'b1;
    logic          start = 1'b0;
    logic [VLW-1:0] vec_len = '0;
    logic          in_valid = 1'b0;
    logic [EB-1:0] in_data = '0;
    logic [EB-1:0] arr_out_data = '0;
    logic          busy, done, w_load, in_ready, pe_step, res_valid;
    logic [1:0]    w_idx;
    logic [EB-1:0] arr_in_data, res_data;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int t0 = 0;

    int step_t[$];
    int hs_t[$];
    int res_t[$];
    int done_t[$];
    int wl_idx[$];

    bit            m_init = 1'b0;
    bit            m_active = 1'b0;
    bit            m_done_cyc = 1'b0;
    bit            m_rv = 1'b0;
    int            m_s = 0;
    int            m_w = 0;
    int            m_len = 0;
    logic [EB-1:0] m_arr = '0;
    logic [EB-1:0] m_rd = '0;

    systolic_ctrl #(
        .ELEMENT_BITS(EB),
        .N_PE(NP),
        .P(PP),
        .VEC_LEN_W(VLW)
    ) dut (
        .sys_clk(sys_clk),
        .reset(reset),
        .start(start),
        .vec_len(vec_len),
        .busy(busy),
        .done(done),
        .w_load(w_load),
        .w_idx(w_idx),
        .in_valid(in_valid),
        .in_data(in_data),
        .in_ready(in_ready),
        .pe_step(pe_step),
        .arr_in_data(arr_in_data),
        .arr_out_data(arr_out_data),
        .res_valid(res_valid),
        .res_data(res_data)
    );

    always #5 sys_clk = ~sys_clk;

    always @(posedge sys_clk) cyc <= cyc + 1;

    task automatic check_output(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("[TB] FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Model: a pass is a sequence of 2*N_PE+vec_len steps, each at least P cycles after the
    // previous one (or after start), stalling only on streaming steps without input.
    always @(negedge sys_clk) begin
        int total;
        int k;
        bit sp, dp, es, er, ew, idle_now, n_done, n_rv;
        total    = 2 * NP + m_len;
        sp       = m_active && (m_s >= NP) && (m_s < NP + m_len);
        dp       = m_active && (m_s >= NP + m_len);
        ew       = m_active && (m_s < NP);
        er       = sp && (m_w >= PP);
        es       = m_active && (m_w >= PP) && (!sp || in_valid);
        idle_now = !m_active && !m_done_cyc;
        n_done   = 1'b0;
        n_rv     = 1'b0;
        k        = m_s - NP;

        if (m_init) begin
            check_output("busy", busy, m_active || m_done_cyc);
            check_output("done", done, m_done_cyc);
            check_output("w_load", w_load, ew);
            check_output("w_idx", w_idx, ew ? m_s : 0);
            check_output("in_ready", in_ready, er);
            check_output("pe_step", pe_step, es);
            check_output("arr_in_data", arr_in_data, m_arr);
            check_output("res_valid", res_valid, m_rv);
            if (m_rv) check_output("res_data", res_data, m_rd);
            if (pe_step) step_t.push_back(cyc - t0);
            if (pe_step && w_load) wl_idx.push_back(int'(w_idx));
            if (in_valid && in_ready) hs_t.push_back(cyc - t0);
            if (res_valid) res_t.push_back(cyc - t0);
            if (done) done_t.push_back(cyc - t0);
        end

        if (reset) begin
            m_init     = 1'b1;
            m_active   = 1'b0;
            m_done_cyc = 1'b0;
            m_rv       = 1'b0;
            m_s        = 0;
            m_w        = 0;
            m_len      = 0;
            m_arr      = '0;
            m_rd       = '0;
        end else if (m_init) begin
            if (es) begin
                if (k >= NP && k < m_len + NP) begin
                    n_rv = 1'b1;
                    m_rd = arr_out_data;
                end
                if (sp) m_arr = in_data;
                else if (dp) m_arr = '0;
                m_s++;
                m_w = 1;
                if (m_s == total) begin
                    m_active = 1'b0;
                    n_done   = 1'b1;
                end
            end else if (m_active) begin
                m_w++;
                if (m_len == 0) begin
                    m_active = 1'b0;
                    n_done   = 1'b1;
                end
            end
            if (idle_now && start) begin
                m_active = 1'b1;
                m_s      = 0;
                m_w      = 1;
                m_len    = int'(vec_len);
            end
            m_done_cyc = n_done;
            m_rv       = n_rv;
        end
    end

    task automatic tick();
        @(posedge sys_clk);
        #1;
        in_data      = EB'($urandom);
        arr_out_data = EB'($urandom);
    endtask

    task automatic clear_events();
        step_t.delete();
        hs_t.delete();
        res_t.delete();
        done_t.delete();
        wl_idx.delete();
    endtask

    // One pass: start at relative cycle 0, in_valid low for sl cycles from sf,
    // an extra start pulse (with a different vec_len) at rs while busy.
    task automatic apply_stimulus(input int len, input int sf, input int sl, input int rs);
        bit fin;
        fin = 1'b0;
        clear_events();
        t0 = cyc;
        for (int r = 0; r < 1500 && !fin; r++) begin
            start    = (r == 0) || (r == rs);
            vec_len  = (r == rs) ? 8'd7 : VLW'(len);
            in_valid = !(r >= sf && r < sf + sl);
            tick();
            if (done_t.size() > 0) fin = 1'b1;
        end
        start    = 1'b0;
        in_valid = 1'b1;
        if (!fin) check_output("pass_timeout", 0, 1);
        tick();
        tick();
    endtask

    initial begin
        reset = 1'b1;
        tick();
        tick();
        tick();
        reset = 1'b0;
        clear_events();
        for (int i = 0; i < 20; i++) tick();
        check_output("idle_steps", step_t.size(), 0);
        check_output("idle_busy", busy, 0);

        // Nominal pass, vec_len=3, input always available.
        apply_stimulus(3, 1000, 0, -1);
        check_output("s1_step_cnt", step_t.size(), 11);
        for (int i = 0; i < step_t.size() && i < 11; i++)
            check_output("s1_step_time", step_t[i], 4 * (i + 1));
        check_output("s1_wload_cnt", wl_idx.size(), 4);
        for (int i = 0; i < wl_idx.size() && i < 4; i++)
            check_output("s1_w_idx", wl_idx[i], i);
        check_output("s1_hs_cnt", hs_t.size(), 3);
        for (int i = 0; i < hs_t.size() && i < 3; i++)
            check_output("s1_hs_time", hs_t[i], 20 + 4 * i);
        check_output("s1_res_cnt", res_t.size(), 3);
        for (int i = 0; i < res_t.size() && i < 3; i++)
            check_output("s1_res_time", res_t[i], 37 + 4 * i);
        check_output("s1_done_cnt", done_t.size(), 1);
        if (done_t.size() > 0) check_output("s1_done_time", done_t[0], 45);

        // Stall: in_valid low for cycles 19..24, fifth step waits for the element.
        apply_stimulus(3, 19, 6, -1);
        check_output("s2_step_cnt", step_t.size(), 11);
        if (step_t.size() > 4) check_output("s2_step5_time", step_t[4], 25);
        if (hs_t.size() > 0) check_output("s2_hs0_time", hs_t[0], 25);
        check_output("s2_res_cnt", res_t.size(), 3);
        check_output("s2_done_cnt", done_t.size(), 1);

        // Empty pass.
        apply_stimulus(0, 1000, 0, -1);
        check_output("s3_step_cnt", step_t.size(), 0);
        check_output("s3_hs_cnt", hs_t.size(), 0);
        check_output("s3_res_cnt", res_t.size(), 0);
        check_output("s3_done_cnt", done_t.size(), 1);
        if (done_t.size() > 0) check_output("s3_done_time", done_t[0], 2);

        // Start pulsed while busy is ignored.
        apply_stimulus(3, 1000, 0, 10);
        check_output("s4_step_cnt", step_t.size(), 11);
        check_output("s4_res_cnt", res_t.size(), 3);
        if (done_t.size() > 0) check_output("s4_done_time", done_t[0], 45);

        // Reset in the middle of streaming.
        clear_events();
        t0 = cyc;
        for (int r = 0; r < 22; r++) begin
            start    = (r == 0);
            vec_len  = 8'd3;
            in_valid = 1'b1;
            tick();
        end
        start = 1'b0;
        reset = 1'b1;
        tick();
        reset = 1'b0;
        check_output("s5_busy_after_reset", busy, 0);
        check_output("s5_ready_after_reset", in_ready, 0);
        check_output("s5_arr_after_reset", arr_in_data, 0);
        for (int i = 0; i < 10; i++) tick();
        check_output("s5_no_done", done_t.size(), 0);

        // Fresh pass after the abort.
        apply_stimulus(5, 1000, 0, -1);
        check_output("s6_res_cnt", res_t.size(), 5);
        if (done_t.size() > 0) check_output("s6_done_time", done_t[0], 53);

        // Maximum vector length.
        apply_stimulus(255, 1000, 0, -1);
        check_output("s7_step_cnt", step_t.size(), 263);
        check_output("s7_res_cnt", res_t.size(), 255);
        if (done_t.size() > 0) check_output("s7_done_time", done_t[0], 1053);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
